// File: rtl/ps2_arrow_decoder.sv
// PS/2 keyboard receiver that turns extended arrow-key make codes
// (E0 75/72/74/6B) into one-cycle up/down/right/left pulses on clk.
// The raw PS/2 lines are synchronised and the clock is glitch-filtered.
// Frames are received LSB first and checked for odd parity and the stop bit.
// A stalled frame is aborted by a timeout.
module ps2_arrow_decoder #(
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       up,
   output logic       down,
   output logic       right,
   output logic       left,
   output logic       key_valid,
   output logic [7:0] scan_code,
   output logic       frame_err
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
   localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES - 1);

   localparam logic [7:0] CODE_EXT = 8'hE0;
   localparam logic [7:0] CODE_BRK = 8'hF0;

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   state_t          state, state_nxt;
   logic            ps2_clk_p0, ps2_clk_p1;
   logic            ps2_data_p0, ps2_data_p1;
   logic            clk_filt;
   logic [FW-1:0]   filt_cnt;
   logic            strobe;
   logic [TW-1:0]   to_cnt;
   logic [7:0]      shreg;
   logic [2:0]      bit_cnt;
   logic            par_bit;
   logic            frame_done;
   logic            frame_ok;
   logic            frame_bad;
   logic            timeout_hit;
   logic            ext, brk;
   logic [3:0]      dir_q;

   // One-hot {up,down,right,left} for an arrow make code, zero otherwise.
   function automatic logic [3:0] arrow_dir(input logic [7:0] code);
      logic [3:0] d;
      case (code)
         8'h75:   d = 4'b1000;
         8'h72:   d = 4'b0100;
         8'h74:   d = 4'b0010;
         8'h6B:   d = 4'b0001;
         default: d = 4'b0000;
      endcase
      return d;
   endfunction

   // Two-flop synchronisers; both lines idle high, so reset them high.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ps2_clk_p0  <= 1'b1;
         ps2_clk_p1  <= 1'b1;
         ps2_data_p0 <= 1'b1;
         ps2_data_p1 <= 1'b1;
      end else begin
         ps2_clk_p0  <= ps2_clk;
         ps2_clk_p1  <= ps2_clk_p0;
         ps2_data_p0 <= ps2_data;
         ps2_data_p1 <= ps2_data_p0;
      end
   end

   // Glitch filter: the filtered clock only follows the synchronised clock
   // after FILTER_LEN consecutive samples that differ from it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clk_filt <= 1'b1;
         filt_cnt <= '0;
      end else if (ps2_clk_p1 == clk_filt) begin
         filt_cnt <= '0;
      end else if (filt_cnt == FILT_MAX) begin
         clk_filt <= ps2_clk_p1;
         filt_cnt <= '0;
      end else begin
         filt_cnt <= filt_cnt + 1'b1;
      end
   end

   // Sample strobe is the cycle in which the filtered clock falls.
   assign strobe = clk_filt && !ps2_clk_p1 && (filt_cnt == FILT_MAX);

   // Timeout counter: cycles since the last strobe while a frame is open.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         to_cnt <= '0;
      end else if (state == IDLE || strobe || timeout_hit) begin
         to_cnt <= '0;
      end else begin
         to_cnt <= to_cnt + 1'b1;
      end
   end

   // Frame state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic; the timeout wins over any strobe-driven move.
   always_comb begin
      state_nxt   = state;
      frame_done  = 1'b0;
      timeout_hit = 1'b0;
      if (state != IDLE && !strobe && to_cnt == TO_MAX) begin
         timeout_hit = 1'b1;
         state_nxt   = IDLE;
      end else if (strobe) begin
         case (state)
            IDLE:    if (!ps2_data_p1) state_nxt = DATA;
            DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
            PARITY:  state_nxt = STOP;
            STOP: begin
               state_nxt  = IDLE;
               frame_done = 1'b1;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Good frame: odd parity across data and parity bit, stop bit high.
   assign frame_ok  = frame_done && ps2_data_p1 && (^{shreg, par_bit});
   assign frame_bad = (frame_done && !frame_ok) || timeout_hit;

   // Bit capture: data shifts in LSB first, parity is kept separately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shreg   <= 8'h00;
         bit_cnt <= 3'd0;
         par_bit <= 1'b0;
      end else if (strobe) begin
         case (state)
            IDLE:    bit_cnt <= 3'd0;
            DATA: begin
               shreg   <= {ps2_data_p1, shreg[7:1]};
               bit_cnt <= bit_cnt + 1'b1;
            end
            PARITY:  par_bit <= ps2_data_p1;
            default: ;
         endcase
      end
   end

   // Byte decoder: track E0/F0 prefixes and pulse outputs one cycle after
   // the stop-bit strobe; any frame error drops the pending prefixes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         key_valid <= 1'b0;
         frame_err <= 1'b0;
         scan_code <= 8'h00;
         dir_q     <= 4'b0000;
         ext       <= 1'b0;
         brk       <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         frame_err <= 1'b0;
         dir_q     <= 4'b0000;
         if (frame_bad) begin
            frame_err <= 1'b1;
            ext       <= 1'b0;
            brk       <= 1'b0;
         end else if (frame_ok) begin
            key_valid <= 1'b1;
            scan_code <= shreg;
            if (shreg == CODE_EXT) begin
               ext <= 1'b1;
            end else if (shreg == CODE_BRK) begin
               brk <= 1'b1;
            end else begin
               if (ext && !brk) dir_q <= arrow_dir(shreg);
               ext <= 1'b0;
               brk <= 1'b0;
            end
         end
      end
   end

   assign {up, down, right, left} = dir_q;

endmodule

// File: tb/tb_ps2_arrow_decoder.sv
// Bench for ps2_arrow_decoder: directed scenarios plus random byte streams
// compared against a prefix-history model of the keyboard protocol.
module tb_ps2_arrow_decoder;

   localparam int FILTER_LEN = 4;
   localparam int TO_CYC     = 300;
   localparam int HALF       = 20;

   logic       clk = 1'b0;
   logic       rst;
   logic       ps2_clk;
   logic       ps2_data;
   logic       up, down, right, left;
   logic       key_valid;
   logic [7:0] scan_code;
   logic       frame_err;

   int n_checks = 0;
   int n_pass   = 0;

   int tot_kv = 0, tot_err = 0, tot_u = 0, tot_d = 0, tot_r = 0, tot_l = 0;
   int viol = 0;

   logic [7:0] pending[$];
   logic [7:0] last_good = 8'h00;

   ps2_arrow_decoder #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TO_CYC)) dut (
      .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .up(up), .down(down), .right(right), .left(left),
      .key_valid(key_valid), .scan_code(scan_code), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   // Pulse totals and protocol-rule violations, sampled mid-cycle.
   always @(negedge clk) begin
      tot_kv  <= tot_kv  + int'(key_valid);
      tot_err <= tot_err + int'(frame_err);
      tot_u   <= tot_u   + int'(up);
      tot_d   <= tot_d   + int'(down);
      tot_r   <= tot_r   + int'(right);
      tot_l   <= tot_l   + int'(left);
      if ((int'(up) + int'(down) + int'(right) + int'(left)) > 1 ||
          ((up || down || right || left) && !key_valid))
         viol <= viol + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic ps2_bit(input logic b);
      ps2_data = b;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
   endtask

   task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
      logic [10:0] fr;
      fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) ps2_bit(fr[i]);
      repeat (10) @(negedge clk);
   endtask

   // Expected outcome of one received byte from the protocol rules:
   // a make code pulses only when the prefixes since the last completed
   // code include E0 and no F0.
   task automatic model_byte(input logic [7:0] b, input bit good,
                             output int kv, output int err, output logic [31:0] dir);
      bit has_e0, has_f0;
      kv = 0; err = 0; dir = 0;
      if (!good) begin
         err = 1;
         pending.delete();
         return;
      end
      kv = 1;
      last_good = b;
      if (b == 8'hE0 || b == 8'hF0) begin
         pending.push_back(b);
         return;
      end
      has_e0 = 0; has_f0 = 0;
      foreach (pending[i]) begin
         if (pending[i] == 8'hE0) has_e0 = 1;
         if (pending[i] == 8'hF0) has_f0 = 1;
      end
      if (has_e0 && !has_f0) begin
         case (b)
            8'h75: dir = 32'h01000000;
            8'h72: dir = 32'h00010000;
            8'h74: dir = 32'h00000100;
            8'h6B: dir = 32'h00000001;
            default: dir = 0;
         endcase
      end
      pending.delete();
   endtask

   task automatic xfer(input string tag, input logic [7:0] b, input bit bad_par, input bit bad_stop);
      int kv0, err0, u0, d0, r0, l0, ekv, eerr;
      logic [31:0] edir, gdir;
      kv0 = tot_kv; err0 = tot_err; u0 = tot_u; d0 = tot_d; r0 = tot_r; l0 = tot_l;
      send_bits(b, bad_par, bad_stop, 11);
      model_byte(b, !bad_par && !bad_stop, ekv, eerr, edir);
      gdir = {8'(tot_u - u0), 8'(tot_d - d0), 8'(tot_r - r0), 8'(tot_l - l0)};
      check_eq({tag, "_kv"},   32'(tot_kv - kv0), 32'(ekv));
      check_eq({tag, "_err"},  32'(tot_err - err0), 32'(eerr));
      check_eq({tag, "_dir"},  gdir, edir);
      check_eq({tag, "_scan"}, 32'(scan_code), 32'(last_good));
   endtask

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_dir"},  32'({up, down, right, left}), 32'h0);
      check_eq({tag, "_kv"},   32'(key_valid), 32'h0);
      check_eq({tag, "_err"},  32'(frame_err), 32'h0);
      check_eq({tag, "_scan"}, 32'(scan_code), 32'h0);
   endtask

   initial begin
      int kv0, err0;
      logic [7:0] arrows [4];
      arrows[0] = 8'h75; arrows[1] = 8'h72; arrows[2] = 8'h74; arrows[3] = 8'h6B;

      rst = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
      repeat (5) @(negedge clk);
      check_idle_outputs("reset");
      rst = 1'b1;
      repeat (5) @(negedge clk);

      // Basic extended make, break sequence, unprefixed code.
      xfer("t1_e0", 8'hE0, 0, 0);
      xfer("t1_75", 8'h75, 0, 0);
      xfer("t2_e0", 8'hE0, 0, 0);
      xfer("t2_f0", 8'hF0, 0, 0);
      xfer("t2_74", 8'h74, 0, 0);
      xfer("t3_6b", 8'h6B, 0, 0);
      xfer("t3_e0", 8'hE0, 0, 0);
      xfer("t3_6b2", 8'h6B, 0, 0);

      // Parity error drops the prefix; bad stop bit likewise.
      xfer("t4_e0", 8'hE0, 0, 0);
      xfer("t4_bad", 8'h72, 1, 0);
      xfer("t4_72", 8'h72, 0, 0);
      xfer("t4_e0b", 8'hE0, 0, 0);
      xfer("t4_stp", 8'h72, 0, 1);
      xfer("t4_72b", 8'h72, 0, 0);

      // Stalled frame after 5 bits times out.
      xfer("t5_e0", 8'hE0, 0, 0);
      kv0 = tot_kv; err0 = tot_err;
      send_bits(8'h75, 0, 0, 5);
      repeat (TO_CYC + 100) @(negedge clk);
      pending.delete();
      check_eq("t5_to_err", 32'(tot_err - err0), 32'd1);
      check_eq("t5_to_kv",  32'(tot_kv - kv0), 32'd0);
      xfer("t5_e0b", 8'hE0, 0, 0);
      xfer("t5_75",  8'h75, 0, 0);

      // Short low glitches on ps2_clk must not produce strobes.
      kv0 = tot_kv; err0 = tot_err;
      for (int i = 0; i < 8; i++) begin
         ps2_data = 1'(i & 1);
         ps2_clk = 1'b0;
         repeat (2) @(negedge clk);
         ps2_clk = 1'b1;
         repeat (12) @(negedge clk);
      end
      ps2_data = 1'b1;
      repeat (TO_CYC + 50) @(negedge clk);
      check_eq("t6_gl_kv",  32'(tot_kv - kv0), 32'd0);
      check_eq("t6_gl_err", 32'(tot_err - err0), 32'd0);
      xfer("t6_e0", 8'hE0, 0, 0);
      xfer("t6_6b", 8'h6B, 0, 0);

      // Reset mid-frame with a pending prefix.
      xfer("t6_e0r", 8'hE0, 0, 0);
      send_bits(8'h74, 0, 0, 5);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_idle_outputs("t6_rst");
      pending.delete();
      last_good = 8'h00;
      ps2_data = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      xfer("t6_74", 8'h74, 0, 0);
      xfer("t6_e0c", 8'hE0, 0, 0);
      xfer("t6_74b", 8'h74, 0, 0);

      // Random byte stream weighted toward arrow sequences.
      for (int i = 0; i < 30; i++) begin
         int sel, e;
         logic [7:0] b;
         sel = int'($urandom_range(0, 9));
         if (sel < 3)      b = 8'hE0;
         else if (sel < 4) b = 8'hF0;
         else if (sel < 8) b = arrows[$urandom_range(0, 3)];
         else              b = 8'($urandom);
         e = int'($urandom_range(0, 11));
         xfer("rnd", b, e == 0, e == 1);
      end

      check_eq("dir_rules", 32'(viol), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
